// File: rtl/main_control_fsm.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch, decode and the
// per-instruction execute steps, plus the PC enable combining jumps and taken branches.
module main_control_fsm #(
  parameter int Opcode_Size = 6,
  parameter int State_Size  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [Opcode_Size-1:0] Opcode,
  input  logic                   ZeroFlag,
  output logic                   IorD,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [1:0]             PCSrc,
  output logic                   PCEn,
  output logic [State_Size-1:0]  StateOut
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [Opcode_Size-1:0] OP_LW    = Opcode_Size'(6'b100011);
  localparam logic [Opcode_Size-1:0] OP_SW    = Opcode_Size'(6'b101011);
  localparam logic [Opcode_Size-1:0] OP_RTYPE = Opcode_Size'(6'b000000);
  localparam logic [Opcode_Size-1:0] OP_BEQ   = Opcode_Size'(6'b000100);
  localparam logic [Opcode_Size-1:0] OP_ADDI  = Opcode_Size'(6'b001000);
  localparam logic [Opcode_Size-1:0] OP_J     = Opcode_Size'(6'b000010);

  state_t state, state_next;

  logic ir_write_dec, pc_write_dec, mem_write_dec, reg_write_dec, branch_dec;

  always_ff @(posedge CLK) begin
    if (RST) state <= FETCH;
    else     state <= state_next;
  end

  // State decode and next-state selection; unused encodings fall to the default.
  always_comb begin
    state_next    = FETCH;
    IorD          = 1'b0;
    mem_write_dec = 1'b0;
    ir_write_dec  = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    reg_write_dec = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSrc         = 2'b00;
    pc_write_dec  = 1'b0;
    branch_dec    = 1'b0;
    case (state)
      FETCH: begin
        ir_write_dec = 1'b1;
        pc_write_dec = 1'b1;
        ALUSrcB      = 2'b01;
        state_next   = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        if (Opcode == OP_LW || Opcode == OP_SW) state_next = MEMADR;
        else if (Opcode == OP_RTYPE)            state_next = EXECUTE;
        else if (Opcode == OP_BEQ)              state_next = BRANCH;
        else if (Opcode == OP_ADDI)             state_next = ADDIEXEC;
        else if (Opcode == OP_J)                state_next = JUMP;
        else                                    state_next = FETCH;
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (Opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        IorD       = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        MemtoReg      = 1'b1;
        reg_write_dec = 1'b1;
      end
      MEMWRITE: begin
        IorD          = 1'b1;
        mem_write_dec = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegDst        = 1'b1;
        reg_write_dec = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSrc      = 2'b01;
        branch_dec = 1'b1;
      end
      ADDIEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        reg_write_dec = 1'b1;
      end
      JUMP: begin
        PCSrc        = 2'b10;
        pc_write_dec = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // Reset masks every architectural write so a held reset cannot corrupt PC, IR, memory or registers.
  assign IRWrite  = ir_write_dec & ~RST;
  assign MemWrite = mem_write_dec & ~RST;
  assign RegWrite = reg_write_dec & ~RST;
  assign PCEn     = (pc_write_dec | (branch_dec & ZeroFlag)) & ~RST;
  assign StateOut = State_Size'(state);

endmodule
